stopwatch_time_counter: RTL and testbench

//  Datapath end of the stopwatch run/pause/reset interface. Consumes count_en and

---
 rtl/stopwatch_pkg.sv | 24 ++
 rtl/stopwatch_time_counter_bcd_digit_counter.sv | 42 ++++
 rtl/stopwatch_time_counter.sv | 81 ++++++++
 tb/tb_stopwatch_time_counter.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared stopwatch constants: BCD digit limits and control FSM state encodings.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package stopwatch_pkg;

    localparam int DIGIT_W = 4;

    localparam logic [DIGIT_W-1:0] SEC_TENS_MAX = 4'd5;
    localparam logic [DIGIT_W-1:0] BCD_MAX      = 4'd9;

    // Run/pause/reset states shared by the control FSM and the display logic
    typedef enum logic [1:0] {
        RES   = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } sw_state_t;

    // Next value of a BCD digit that wraps to zero after max
    function automatic logic [DIGIT_W-1:0] bcd_next(input logic [DIGIT_W-1:0] q,
                                                    input logic [DIGIT_W-1:0] max);
        return (q == max) ? '0 : q + DIGIT_W'(1);
    endfunction

endpackage

// File: rtl/stopwatch_time_counter_bcd_digit_counter.sv
// One BCD time digit counting 0..MAX, with a combinational carry out for chaining.
// Latency: q updates on the edge after inc; carry is same-cycle.
// Backpressure: none; clr overrides inc, hold when neither is set.
module bcd_digit_counter
    import stopwatch_pkg::*;
#(
    parameter logic [DIGIT_W-1:0] MAX = BCD_MAX
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               inc,
    output logic [DIGIT_W-1:0] q,
    output logic               carry
);

    logic [DIGIT_W-1:0] q_q;
    logic [DIGIT_W-1:0] q_d;

    // Next digit value: clear first, then step with wrap, otherwise hold
    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (inc) begin
            q_d = bcd_next(q_q, MAX);
        end
    end

    // Digit register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q     = q_q;
    assign carry = inc & (q_q == MAX);

endmodule

// File: rtl/stopwatch_time_counter.sv
// Seconds prescaler plus MM:SS BCD time counter with one-cycle sec_tick/rollover pulses.
// Latency: digits and pulses update one cycle after the terminal prescaler edge.
// Backpressure: none; count_en=0 holds all state, clear zeroes it.
module stopwatch_time_counter
    import stopwatch_pkg::*;
#(
    parameter int CLK_DIV = 100_000_000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               count_en,
    input  logic               clear,
    output logic [DIGIT_W-1:0] sec_ones,
    output logic [DIGIT_W-1:0] sec_tens,
    output logic [DIGIT_W-1:0] min_ones,
    output logic [DIGIT_W-1:0] min_tens,
    output logic               sec_tick,
    output logic               rollover
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(CLK_DIV - 1);

    logic [PW-1:0] pre_q, pre_d;
    logic          sec_tick_q, sec_tick_d;
    logic          rollover_q, rollover_d;

    logic          pre_term;
    logic          sec_inc;
    logic          c_so, c_st, c_mo, c_mt;

    // A second completes on an enabled cycle at the last prescaler count; clear cancels it
    assign pre_term = count_en & (pre_q == PRE_LAST);
    assign sec_inc  = pre_term & ~clear;

    // Prescaler and pulse next-state; pause keeps the partial second
    always_comb begin
        pre_d      = pre_q;
        sec_tick_d = sec_inc;
        rollover_d = c_mt;
        if (clear) begin
            pre_d = '0;
        end else if (count_en) begin
            pre_d = pre_term ? '0 : pre_q + PW'(1);
        end
    end

    // Prescaler and pulse registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q      <= '0;
            sec_tick_q <= 1'b0;
            rollover_q <= 1'b0;
        end else begin
            pre_q      <= pre_d;
            sec_tick_q <= sec_tick_d;
            rollover_q <= rollover_d;
        end
    end

    bcd_digit_counter #(.MAX(BCD_MAX)) u_sec_ones (
        .clk(clk), .rst(rst), .clr(clear), .inc(sec_inc), .q(sec_ones), .carry(c_so)
    );

    bcd_digit_counter #(.MAX(SEC_TENS_MAX)) u_sec_tens (
        .clk(clk), .rst(rst), .clr(clear), .inc(c_so), .q(sec_tens), .carry(c_st)
    );

    bcd_digit_counter #(.MAX(BCD_MAX)) u_min_ones (
        .clk(clk), .rst(rst), .clr(clear), .inc(c_st), .q(min_ones), .carry(c_mo)
    );

    // Carry out of the top digit marks the 99:59 -> 00:00 wrap
    bcd_digit_counter #(.MAX(BCD_MAX)) u_min_tens (
        .clk(clk), .rst(rst), .clr(clear), .inc(c_mo), .q(min_tens), .carry(c_mt)
    );

    assign sec_tick = sec_tick_q;
    assign rollover = rollover_q;

endmodule

// File: tb/tb_stopwatch_time_counter.sv
// Scoreboard bench: two DUTs (CLK_DIV=4 and CLK_DIV=1) against an elapsed-seconds model.
// Latency: expected values are queued at each edge and popped on the following falling edge.
// Backpressure: n/a.
module tb_stopwatch_time_counter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic count_en = 1'b0;
    logic clear = 1'b0;

    logic [3:0] s4_so, s4_st, s4_mo, s4_mt;
    logic       s4_tick, s4_roll;
    logic [3:0] s1_so, s1_st, s1_mo, s1_mt;
    logic       s1_tick, s1_roll;

    always #5 clk = ~clk;

    stopwatch_time_counter #(.CLK_DIV(4)) dut4 (
        .clk(clk), .rst(rst), .count_en(count_en), .clear(clear),
        .sec_ones(s4_so), .sec_tens(s4_st), .min_ones(s4_mo), .min_tens(s4_mt),
        .sec_tick(s4_tick), .rollover(s4_roll)
    );

    stopwatch_time_counter #(.CLK_DIV(1)) dut1 (
        .clk(clk), .rst(rst), .count_en(count_en), .clear(clear),
        .sec_ones(s1_so), .sec_tens(s1_st), .min_ones(s1_mo), .min_tens(s1_mt),
        .sec_tick(s1_tick), .rollover(s1_roll)
    );

    wire [15:0] d4 = {s4_mt, s4_mo, s4_st, s4_so};
    wire [15:0] d1 = {s1_mt, s1_mo, s1_st, s1_so};

    typedef struct {
        logic [15:0] digits;
        logic        tick;
        logic        roll;
    } exp_t;

    exp_t q4[$];
    exp_t q1[$];

    int checks = 0;
    int errors = 0;

    // Reference model: elapsed whole seconds plus clock cycles into the current second
    int secs[2];
    int sub[2];
    int div[2] = '{4, 1};

    function automatic logic [15:0] to_bcd(input int s);
        int mm, ss;
        mm = s / 60;
        ss = s % 60;
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    task automatic model_step(input int i, input logic r, input logic e, input logic c,
                              output exp_t x);
        x.tick = 1'b0;
        x.roll = 1'b0;
        if (r || c) begin
            secs[i] = 0;
            sub[i]  = 0;
        end else if (e) begin
            sub[i] = sub[i] + 1;
            if (sub[i] == div[i]) begin
                sub[i]  = 0;
                secs[i] = (secs[i] + 1) % 6000;
                x.tick  = 1'b1;
                x.roll  = (secs[i] == 0);
            end
        end
        x.digits = to_bcd(secs[i]);
    endtask

    // One clock: apply inputs, queue the model response for the edge, release after the edge
    task automatic cyc(input logic r, input logic e, input logic c);
        exp_t x;
        rst = r;
        count_en = e;
        clear = c;
        @(posedge clk);
        model_step(0, r, e, c, x);
        q4.push_back(x);
        model_step(1, r, e, c, x);
        q1.push_back(x);
        #1;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cyc(1'b0, 1'b1, 1'b0);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: compare every registered output against the queued model response
    always @(negedge clk) begin
        exp_t e;
        if (q4.size() > 0) begin
            e = q4.pop_front();
            checks++;
            if ({d4, s4_tick, s4_roll} !== {e.digits, e.tick, e.roll}) begin
                errors++;
                $display("FAIL sb_div4 got %h tick=%b roll=%b expected %h tick=%b roll=%b",
                         d4, s4_tick, s4_roll, e.digits, e.tick, e.roll);
            end
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            checks++;
            if ({d1, s1_tick, s1_roll} !== {e.digits, e.tick, e.roll}) begin
                errors++;
                $display("FAIL sb_div1 got %h tick=%b roll=%b expected %h tick=%b roll=%b",
                         d1, s1_tick, s1_roll, e.digits, e.tick, e.roll);
            end
        end
    end

    initial begin
        logic [11:0] tv;
        logic [11:0] tv_exp;
        logic        ro;
        int          rc;
        int          bad;

        // Reset
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        chk("reset_digits", 32'(d4), 32'h0);
        chk("reset_pulses", {30'd0, s4_tick, s4_roll}, 32'h0);

        // Twelve enabled cycles: ticks on cycles 4, 8, 12
        tv = '0;
        ro = 1'b0;
        for (int i = 0; i < 12; i++) begin
            cyc(1'b0, 1'b1, 1'b0);
            tv[i] = s4_tick;
            ro = ro | s4_roll;
        end
        tv_exp = '0;
        tv_exp[3] = 1'b1;
        tv_exp[7] = 1'b1;
        tv_exp[11] = 1'b1;
        chk("t1_digits", 32'(d4), 32'h0003);
        chk("t1_tick_spacing", 32'(tv), 32'(tv_exp));
        chk("t1_no_rollover", 32'(ro), 32'h0);

        // Pause mid-second keeps the partial count
        cyc(1'b0, 1'b0, 1'b1);
        run(10);
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 1'b0);
        chk("t2_paused_digits", 32'(d4), 32'h0002);
        cyc(1'b0, 1'b1, 1'b0);
        chk("t2_no_early_tick", 32'(s4_tick), 32'h0);
        cyc(1'b0, 1'b1, 1'b0);
        chk("t2_resume_tick", 32'(s4_tick), 32'h1);
        chk("t2_resume_digits", 32'(d4), 32'h0003);

        // Carries into minutes and tens of minutes
        cyc(1'b0, 1'b0, 1'b1);
        run(240);
        chk("t3_one_minute", {15'd0, s4_tick, d4}, {15'd0, 1'b1, 16'h0100});
        run(2160);
        chk("t3_ten_minutes", 32'(d4), 32'h1000);

        // Clear beats a terminal prescaler count
        cyc(1'b0, 1'b0, 1'b1);
        run(31);
        chk("t5_before_clear", 32'(d4), 32'h0007);
        cyc(1'b0, 1'b1, 1'b1);
        chk("t5_cleared", {15'd0, s4_tick, d4}, 32'h0);
        tv = '0;
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b1, 1'b0);
            tv[i] = s4_tick;
        end
        chk("t5_prescaler_restart", 32'(tv), 32'h8);

        // CLK_DIV=1 full wrap
        cyc(1'b0, 1'b0, 1'b1);
        rc = 0;
        bad = 0;
        for (int i = 0; i < 6000; i++) begin
            cyc(1'b0, 1'b1, 1'b0);
            if (s1_roll) begin
                rc++;
                if (!s1_tick) bad++;
            end
        end
        chk("t4_wrapped_digits", 32'(d1), 32'h0);
        chk("t4_rollover_count", 32'(rc), 32'd1);
        chk("t4_rollover_with_tick", 32'(bad), 32'd0);

        // Reset mid-run at 37:42
        cyc(1'b0, 1'b0, 1'b1);
        run(9048);
        chk("t6_before_reset", 32'(d4), 32'h3742);
        cyc(1'b1, 1'b1, 1'b0);
        chk("t6_reset", {14'd0, s4_tick, s4_roll, d4}, 32'h0);
        tv = '0;
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b1, 1'b0);
            tv[i] = s4_tick;
        end
        chk("t6_first_tick", 32'(tv), 32'h8);

        // Randomized run/pause/clear/reset traffic
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 199) == 0),
                ($urandom_range(0, 9) < 7),
                ($urandom_range(0, 99) < 2));
        end

        cyc(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
